theia_bus_scheduler: RTL and testbench

THEIA_BUS_SCHEDULER -- requirements
Module: theia_bus_scheduler

---
 rtl/theia_bus_scheduler_pkg.sv | 14 +
 rtl/theia_bus_scheduler_rr_pick.sv | 39 +++
 rtl/theia_bus_scheduler.sv | 114 +++++++++++
 tb/tb_theia_bus_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/theia_bus_scheduler_pkg.sv
// Shared defaults and FSM state encoding for the Theia bus scheduler.
package theia_bus_scheduler_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int SEL_W_DEF   = 2;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

endpackage

// File: rtl/theia_bus_scheduler_rr_pick.sv
// Round-robin pick: first eligible index at or above rr_ptr, wrapping to the lowest.
// Latency: purely combinational.
// Backpressure: none; valid is low when nothing is eligible.
module rr_pick
   import theia_bus_scheduler_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int SEL_W   = SEL_W_DEF
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [SEL_W-1:0]   rr_ptr,
   output logic [SEL_W-1:0]   winner,
   output logic               valid
);

   logic [SEL_W-1:0] low_any;
   logic [SEL_W-1:0] low_above;
   logic             hit_above;

   // Descending scan so the last hit is the lowest index in each class.
   always_comb begin
      low_any   = '0;
      low_above = '0;
      hit_above = 1'b0;
      valid     = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            low_any = SEL_W'(i);
            valid   = 1'b1;
            if (i >= int'(rr_ptr)) begin
               low_above = SEL_W'(i);
               hit_above = 1'b1;
            end
         end
      end
      winner = hit_above ? low_above : low_any;
   end

endmodule

// File: rtl/theia_bus_scheduler.sv
// Round-robin bus scheduler for NUM_REQ cores with a per-grant ACK watchdog.
// Latency: grant one cycle after an eligible request; ACK routed with zero latency.
// Backpressure: grant held while the owner requests; TIMEOUT stalled cycles revoke it.
module theia_bus_scheduler
   import theia_bus_scheduler_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int SEL_W   = SEL_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               CLK_I,
   input  logic               RST_I,
   input  logic [NUM_REQ-1:0] iRequest,
   input  logic [NUM_REQ-1:0] iStb,
   input  logic [NUM_REQ-1:0] iEnable,
   input  logic               ACK_I,
   output logic [NUM_REQ-1:0] oGrant,
   output logic [SEL_W-1:0]   oBusSelect,
   output logic               oCyc,
   output logic [NUM_REQ-1:0] oAck,
   output logic               oTimeout,
   output logic [SEL_W-1:0]   oErrCore
);

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [SEL_W-1:0] SEL_TOP  = SEL_W'(NUM_REQ - 1);

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q;
   logic [SEL_W-1:0]   rr_ptr_q;
   logic [SEL_W-1:0]   err_q;
   logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;
   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] sel_onehot;
   logic [SEL_W-1:0]   pick_idx;
   logic               pick_vld;
   logic               req_held;
   logic               stb_held;
   logic               stalled;
   logic               expire;
   logic [SEL_W-1:0]   next_ptr;

   assign eligible = iRequest & iEnable;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .SEL_W   (SEL_W)
   ) u_rr_pick (
      .eligible (eligible),
      .rr_ptr   (rr_ptr_q),
      .winner   (pick_idx),
      .valid    (pick_vld)
   );

   always_comb begin
      sel_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_onehot[i] = (sel_q == SEL_W'(i));
      end
   end

   assign req_held = |(iRequest & sel_onehot);
   assign stb_held = |(iStb & sel_onehot);
   assign stalled  = (state_q == ST_GRANT) && stb_held && !ACK_I;
   assign next_ptr = (sel_q == SEL_TOP) ? '0 : sel_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      wd_cnt_d = '0;
      expire   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) state_d = ST_GRANT;
         end
         ST_GRANT: begin
            // A same-cycle ACK_I clears stalled, so it wins over expiry.
            expire = stalled && (wd_cnt_q == CNT_LAST);
            if (expire || !req_held) begin
               state_d = ST_RELEASE;
            end else if (stalled) begin
               wd_cnt_d = (wd_cnt_q == CNT_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         rr_ptr_q <= '0;
         wd_cnt_q <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         wd_cnt_q <= wd_cnt_d;
         if (state_q == ST_IDLE && pick_vld) sel_q <= pick_idx;
         if (expire) err_q <= sel_q;
         if (state_q == ST_RELEASE) rr_ptr_q <= next_ptr;
      end
   end

   assign oGrant     = (state_q == ST_GRANT) ? sel_onehot : '0;
   assign oCyc       = (state_q == ST_GRANT);
   assign oBusSelect = sel_q;
   assign oAck       = (ACK_I && req_held) ? oGrant : '0;
   assign oTimeout   = expire;
   assign oErrCore   = expire ? sel_q : err_q;

endmodule

// File: tb/tb_theia_bus_scheduler.sv
// Directed bench for theia_bus_scheduler with a cycle-level reference model.
module tb_theia_bus_scheduler;

   localparam int N  = 4;
   localparam int SW = 2;
   localparam int TO = 8;
   localparam logic [N-1:0] ALL = 4'b1111;

   logic          CLK_I = 1'b0;
   logic          RST_I = 1'b1;
   logic [N-1:0]  iRequest = '0;
   logic [N-1:0]  iStb = '0;
   logic [N-1:0]  iEnable = '0;
   logic          ACK_I = 1'b0;
   logic [N-1:0]  oGrant;
   logic [SW-1:0] oBusSelect;
   logic          oCyc;
   logic [N-1:0]  oAck;
   logic          oTimeout;
   logic [SW-1:0] oErrCore;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the bus, whether this is the release cycle,
   // where the next search starts, and how long the owner has been stalled.
   int m_owner = -1;
   bit m_rel   = 1'b0;
   int m_next  = 0;
   int m_stall = 0;
   int m_sel   = 0;
   int m_err   = 0;

   logic [N-1:0] e_grant, e_ack;
   logic         e_to;
   int           e_err;

   theia_bus_scheduler #(
      .NUM_REQ (N),
      .SEL_W   (SW),
      .TIMEOUT (TO)
   ) dut (
      .CLK_I      (CLK_I),
      .RST_I      (RST_I),
      .iRequest   (iRequest),
      .iStb       (iStb),
      .iEnable    (iEnable),
      .ACK_I      (ACK_I),
      .oGrant     (oGrant),
      .oBusSelect (oBusSelect),
      .oCyc       (oCyc),
      .oAck       (oAck),
      .oTimeout   (oTimeout),
      .oErrCore   (oErrCore)
   );

   always #5 CLK_I = ~CLK_I;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic calc();
      bit stalled;
      e_grant = '0;
      if (m_owner >= 0) e_grant[m_owner] = 1'b1;
      stalled = (m_owner >= 0) && iStb[m_owner] && !ACK_I;
      e_to    = stalled && (m_stall == TO - 1);
      e_ack   = ((m_owner >= 0) && iRequest[m_owner] && ACK_I) ? e_grant : '0;
      e_err   = e_to ? m_owner : m_err;
   endtask

   task automatic model_step();
      if (RST_I) begin
         m_owner = -1; m_rel = 1'b0; m_next = 0; m_stall = 0; m_sel = 0; m_err = 0;
      end else begin
         calc();
         if (m_owner >= 0) begin
            if (e_to) begin
               m_err = m_owner; m_owner = -1; m_rel = 1'b1; m_stall = 0;
            end else if (!iRequest[m_owner]) begin
               m_owner = -1; m_rel = 1'b1; m_stall = 0;
            end else if (iStb[m_owner] && !ACK_I) begin
               m_stall++;
            end else begin
               m_stall = 0;
            end
         end else if (m_rel) begin
            m_rel  = 1'b0;
            m_next = (m_sel + 1) % N;
         end else begin
            for (int k = 0; k < N; k++) begin
               int idx;
               idx = (m_next + k) % N;
               if (m_owner < 0 && iRequest[idx] && iEnable[idx]) begin
                  m_owner = idx;
                  m_sel   = idx;
               end
            end
         end
      end
   endtask

   task automatic compare();
      if (!RST_I) begin
         calc();
         chk("grant",   oGrant,     e_grant);
         chk("cyc",     oCyc,       m_owner >= 0);
         chk("sel",     oBusSelect, m_sel);
         chk("ack",     oAck,       e_ack);
         chk("timeout", oTimeout,   e_to);
         chk("errcore", oErrCore,   e_err);
         chk("onehot",  $onehot0(oGrant), 1);
         chk("cyc_or",  oCyc,       |oGrant);
      end
   endtask

   task automatic drive(input logic [N-1:0] req, input logic [N-1:0] stb,
                        input logic [N-1:0] en, input logic ack);
      @(posedge CLK_I);
      model_step();
      #1;
      iRequest = req; iStb = stb; iEnable = en; ACK_I = ack;
      @(negedge CLK_I);
      compare();
   endtask

   task automatic release_reset();
      @(posedge CLK_I);
      model_step();
      #1;
      RST_I = 1'b0;
      @(negedge CLK_I);
      compare();
   endtask

   initial begin
      #100000;
      $display("FAIL bench_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] oh;
      int a_order [5] = '{0, 1, 2, 3, 0};
      int c_order [4] = '{0, 2, 0, 2};

      @(negedge CLK_I);
      chk("rst_grant", oGrant, 0);
      chk("rst_cyc", oCyc, 0);
      chk("rst_sel", oBusSelect, 0);
      chk("rst_ack", oAck, 0);
      chk("rst_timeout", oTimeout, 0);
      chk("rst_errcore", oErrCore, 0);
      release_reset();

      // Everyone requesting: strict rotation with a two-cycle gap.
      for (int g = 0; g < 5; g++) begin
         oh = 4'b0001 << a_order[g];
         drive(ALL, '0, ALL, 1'b0);
         chk("A_idle_gap", oGrant, 0);
         drive(ALL, '0, ALL, 1'b0);
         chk("A_order", oGrant, oh);
         drive(ALL, '0, ALL, 1'b0);
         drive(ALL & ~oh, '0, ALL, 1'b0);
         chk("A_last_grant", oGrant, oh);
         drive(ALL, '0, ALL, 1'b0);
         chk("A_release_gap", oGrant, 0);
      end

      // Single request for core 2 and an ACK pulse two cycles into the grant.
      drive(4'b0100, '0, ALL, 1'b0);
      drive(4'b0100, '0, ALL, 1'b0);
      chk("B_grant", oGrant, 4'b0100);
      chk("B_sel", oBusSelect, 2);
      drive(4'b0100, '0, ALL, 1'b0);
      chk("B_ack_pre", oAck, 0);
      drive(4'b0100, '0, ALL, 1'b1);
      chk("B_ack", oAck, 4'b0100);
      drive(4'b0100, '0, ALL, 1'b0);
      chk("B_ack_post", oAck, 0);
      drive('0, '0, ALL, 1'b0);
      drive('0, '0, ALL, 1'b0);
      chk("B_release_sel_hold", oBusSelect, 2);
      drive('0, '0, ALL, 1'b0);

      // Enable mask 0101: only cores 0 and 2 alternate.
      for (int g = 0; g < 4; g++) begin
         oh = 4'b0001 << c_order[g];
         drive(ALL, '0, 4'b0101, 1'b0);
         drive(ALL, '0, 4'b0101, 1'b0);
         chk("C_masked_order", oGrant, oh);
         drive(ALL & ~oh, '0, 4'b0101, 1'b0);
         drive(ALL, '0, 4'b0101, 1'b0);
      end

      // Core 1 stalls with no ACK: revoked on the eighth stalled cycle.
      drive(4'b0110, 4'b0010, ALL, 1'b0);
      for (int k = 1; k <= TO; k++) begin
         drive(4'b0110, 4'b0010, ALL, 1'b0);
         chk("D_grant_core1", oGrant, 4'b0010);
         chk("D_timeout_edge", oTimeout, k == TO);
      end
      chk("D_errcore", oErrCore, 1);
      drive(4'b0110, '0, ALL, 1'b0);
      chk("D_release", oCyc, 0);
      chk("D_pulse_once", oTimeout, 0);
      chk("D_errcore_hold", oErrCore, 1);
      drive(4'b0110, 4'b0100, ALL, 1'b0);
      drive(4'b0110, 4'b0100, ALL, 1'b0);
      chk("D_next_core2", oGrant, 4'b0100);

      // ACK arriving on the would-be expiry cycle keeps the grant.
      for (int k = 2; k < TO; k++) drive(4'b0110, 4'b0100, ALL, 1'b0);
      drive(4'b0110, 4'b0100, ALL, 1'b1);
      chk("E_ack_at_expiry", oAck, 4'b0100);
      chk("E_no_revoke", oTimeout, 0);
      drive(4'b0110, 4'b0100, ALL, 1'b0);
      chk("E_still_granted", oGrant, 4'b0100);
      chk("E_still_no_timeout", oTimeout, 0);
      drive('0, '0, ALL, 1'b0);
      drive('0, '0, ALL, 1'b0);
      drive('0, '0, ALL, 1'b0);

      // Reset in the middle of a grant to core 3.
      drive(4'b1000, '0, ALL, 1'b0);
      drive(4'b1000, '0, ALL, 1'b1);
      chk("F_pre_grant", oGrant, 4'b1000);
      #2;
      RST_I = 1'b1;
      #1;
      chk("F_rst_grant", oGrant, 0);
      chk("F_rst_cyc", oCyc, 0);
      chk("F_rst_sel", oBusSelect, 0);
      chk("F_rst_ack", oAck, 0);
      chk("F_rst_errcore", oErrCore, 0);
      ACK_I = 1'b0;
      iRequest = '0;
      release_reset();
      drive(4'b1001, '0, ALL, 1'b0);
      drive(4'b1001, '0, ALL, 1'b0);
      chk("F_search_from_0", oGrant, 4'b0001);
      drive(4'b1000, '0, ALL, 1'b0);
      drive(4'b1000, '0, ALL, 1'b0);
      drive(4'b1000, '0, ALL, 1'b0);
      drive(4'b1000, '0, ALL, 1'b0);
      chk("F_core3", oGrant, 4'b1000);
      chk("F_core3_sel", oBusSelect, 3);
      drive('0, '0, ALL, 1'b0);
      drive('0, '0, ALL, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
